// File: rtl/board_mem_arbiter_if.sv
// Board RAM arbiter bus bundle.
// Groups the requester handshake signals, the read-return path, the RAM-side
// port and the error flags so the arbiter and its environment share one
// connection object.
//   master : requester/RAM environment (drives req/we/addr/wdata/lock,
//            err_clr and the RAM read data)
//   slave  : the arbiter (drives gnt/rvalid/rdata, mem_* and err)
interface board_mem_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 10,
    parameter int unsigned DW   = 3
);
    // Requester side
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;

    // RAM side
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;

    // Error reporting
    logic [1:0]         err;
    logic               err_clr;

    modport master (
        output req, we, addr, wdata, lock, err_clr, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, err
    );

    modport slave (
        input  req, we, addr, wdata, lock, err_clr, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/board_mem_arbiter.sv
// Board RAM arbiter.
// Shares one single-port 26x26 board RAM (3-bit colour per cell) between the
// VGA scan reader (0), the game logic (1) and the board generator (2).
// Round-robin grant, per-requester read return, an atomic lock for
// read-modify-write sequences with a forced-release timeout, and sticky
// error flags.
//
// Ports:
//   CLOCK    system clock, rising edge
//   RESET_N  asynchronous active-low reset
//   bus      board_mem_arbiter_if.slave:
//              req/we/addr/wdata/lock in, gnt out (combinational, one-hot)
//              rvalid/rdata out (one cycle after a read grant)
//              mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in (1-cycle RAM)
//              err out ([0] address out of range, [1] lock timeout), err_clr in
//
// Build option:
//   ARB_VGA_PRIORITY_EN  requester 0 wins every cycle it requests (even over a
//                        lock owner); its grants leave the rr pointer alone and
//                        its writes are downgraded to reads with err[0] set.
module board_mem_arbiter #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 3,
    parameter int unsigned DEPTH    = 676,
    parameter int unsigned MAX_LOCK = 32
) (
    input  logic                 CLOCK,
    input  logic                 RESET_N,
    board_mem_arbiter_if.slave   bus
);

    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IW1 = IW + 1;
    localparam int unsigned CW  = $clog2(MAX_LOCK + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Registered state
    state_t             state;
    logic [IW-1:0]      rr;
    logic [IW-1:0]      owner;
    logic [CW-1:0]      lock_cnt;
    logic               active;
    logic [NREQ-1:0]    rvalid_q;
    logic               rd_oor_q;
    logic [1:0]         err_q;

    // Grant path
    logic               gnt_any_c;
    logic [IW-1:0]      gnt_idx_c;
    logic [NREQ-1:0]    gnt_vec_c;
    logic [IW1-1:0]     rr_sum_c;

    // Granted requester's request fields
    logic               sel_we_c;
    logic               sel_lock_c;
    logic [AW-1:0]      sel_addr_c;
    logic [DW-1:0]      sel_wdata_c;
    logic               in_range_c;
    logic               we_eff_c;
    logic               bad_wr_c;
    logic               new_oor_c;

    // Lock control
    logic               owner_gnt_c;
    logic               rel_norm_c;
    logic               timeout_c;
    logic               release_c;

    // Priority option hooks
    logic               vga_win_c;
    logic               vga_gnt_c;
    logic               owner_vga_c;

    // Successor of a requester index, wrapping modulo NREQ.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
    endfunction

`ifdef ARB_VGA_PRIORITY_EN
    assign vga_win_c   = active && bus.req[0];
    assign vga_gnt_c   = gnt_any_c && (gnt_idx_c == '0);
    assign owner_vga_c = (owner == '0);
`else
    assign vga_win_c   = 1'b0;
    assign vga_gnt_c   = 1'b0;
    assign owner_vga_c = 1'b0;
`endif

    // Grant selection: VGA override, then lock owner, else round-robin from rr.
    always_comb begin
        gnt_any_c = 1'b0;
        gnt_idx_c = rr;
        rr_sum_c  = '0;
        if (vga_win_c) begin
            gnt_any_c = 1'b1;
            gnt_idx_c = '0;
        end else if (active) begin
            if (state == ST_LOCKED) begin
                if (bus.req[owner]) begin
                    gnt_any_c = 1'b1;
                    gnt_idx_c = owner;
                end
            end else begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    rr_sum_c = {1'b0, rr} + IW1'(k);
                    if (rr_sum_c >= IW1'(NREQ)) begin
                        rr_sum_c = rr_sum_c - IW1'(NREQ);
                    end
                    if (!gnt_any_c && bus.req[IW'(rr_sum_c)]) begin
                        gnt_any_c = 1'b1;
                        gnt_idx_c = IW'(rr_sum_c);
                    end
                end
            end
        end
    end

    // Decode the granted request and drive the RAM port.
    always_comb begin
        sel_we_c    = bus.we[gnt_idx_c];
        sel_lock_c  = bus.lock[gnt_idx_c];
        sel_addr_c  = bus.addr[gnt_idx_c*AW +: AW];
        sel_wdata_c = bus.wdata[gnt_idx_c*DW +: DW];
        in_range_c  = 32'(sel_addr_c) < DEPTH;
        // A VGA write (priority build only) is downgraded to a read.
        we_eff_c    = sel_we_c && !vga_gnt_c;
        bad_wr_c    = sel_we_c && vga_gnt_c;
        new_oor_c   = gnt_any_c && (!in_range_c || bad_wr_c);
        gnt_vec_c   = gnt_any_c ? (NREQ'(1) << gnt_idx_c) : '0;
    end

    assign bus.gnt       = gnt_vec_c;
    assign bus.mem_en    = gnt_any_c && in_range_c;
    assign bus.mem_we    = gnt_any_c && in_range_c && we_eff_c;
    assign bus.mem_addr  = gnt_any_c ? sel_addr_c  : '0;
    assign bus.mem_wdata = gnt_any_c ? sel_wdata_c : '0;

    // Read return: RAM data lands one cycle after the grant; out-of-range
    // reads never touched the RAM, so they return zero.
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = (|rvalid_q && !rd_oor_q) ? bus.mem_rdata : '0;
    assign bus.err    = err_q;

    // Lock release: owner finishes with lock dropped, walks away, or times out.
    always_comb begin
        owner_gnt_c = gnt_any_c && (gnt_idx_c == owner);
        rel_norm_c  = (owner_gnt_c && !bus.lock[owner]) ||
                      (!bus.req[owner] && !bus.lock[owner]);
        timeout_c   = (state == ST_LOCKED) && !rel_norm_c &&
                      (lock_cnt == CW'(MAX_LOCK - 1));
        release_c   = (state == ST_LOCKED) && (rel_norm_c || timeout_c);
    end

    // State, pointer, lock counter, read-return and error registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            rr       <= '0;
            owner    <= '0;
            lock_cnt <= '0;
            active   <= 1'b0;
            rvalid_q <= '0;
            rd_oor_q <= 1'b0;
            err_q    <= '0;
        end else begin
            // Grants open one edge after reset release.
            active   <= 1'b1;
            rvalid_q <= (gnt_any_c && !we_eff_c) ? gnt_vec_c : '0;
            rd_oor_q <= gnt_any_c && !in_range_c;
            // A new error outranks a simultaneous clear.
            err_q    <= (err_q & ~{2{bus.err_clr}}) | {timeout_c, new_oor_c};

            case (state)
                ST_IDLE: begin
                    if (gnt_any_c) begin
                        if (sel_lock_c) begin
                            state    <= ST_LOCKED;
                            owner    <= gnt_idx_c;
                            lock_cnt <= '0;
                        end
                        if (!vga_gnt_c) begin
                            rr <= next_idx(gnt_idx_c);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (release_c) begin
                        state    <= ST_IDLE;
                        lock_cnt <= '0;
                        if (!owner_vga_c) begin
                            rr <= next_idx(owner);
                        end
                    end else begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Testbench for board_mem_arbiter: a transaction-level model checks every
// output on each falling edge; directed scenarios add hand-computed checks.
module tb_board_mem_arbiter;

    localparam int unsigned NREQ     = 3;
    localparam int unsigned AW       = 10;
    localparam int unsigned DW       = 3;
    localparam int unsigned DEPTH    = 676;
    localparam int unsigned MAX_LOCK = 32;

`ifdef ARB_VGA_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b0;

    always #5 CLOCK = ~CLOCK;

    board_mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    board_mem_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Board RAM device with one-cycle read latency.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge CLOCK) begin
        if (bus.mem_en && (int'(bus.mem_addr) < int'(DEPTH))) begin
            if (bus.mem_we) ram[int'(bus.mem_addr)] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[int'(bus.mem_addr)];
        end
    end

    // Reference model: board contents, rr pointer, lock ownership, pending read.
    logic [DW-1:0]   board [DEPTH];
    int              m_rr, m_owner, m_cnt;
    bit              m_locked, m_ready;
    logic [NREQ-1:0] m_rv;
    logic [DW-1:0]   m_rd;
    logic [1:0]      m_err;

    int              g, a, o;
    bit              ok, wr, rel, to, nerr0;
    logic [NREQ-1:0] e_gnt, nrv;
    logic [DW-1:0]   e_wd, nrd;

    always @(negedge CLOCK) begin
        if (!RESET_N) begin
            check("rst_gnt",    32'(bus.gnt),    32'h0);
            check("rst_rvalid", 32'(bus.rvalid), 32'h0);
            check("rst_rdata",  32'(bus.rdata),  32'h0);
            check("rst_mem_en", 32'(bus.mem_en), 32'h0);
            check("rst_mem_we", 32'(bus.mem_we), 32'h0);
            check("rst_err",    32'(bus.err),    32'h0);
            m_rr = 0; m_owner = 0; m_cnt = 0; m_locked = 0; m_ready = 0;
            m_rv = '0; m_rd = '0; m_err = '0;
        end else begin
            g = -1;
            if (m_ready) begin
                if (PRIO && bus.req[0]) g = 0;
                else if (m_locked) begin
                    if (bus.req[m_owner]) g = m_owner;
                end else begin
                    for (int k = 0; k < int'(NREQ); k++) begin
                        if (g < 0 && bus.req[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
                    end
                end
            end
            a = 0; ok = 0; wr = 0; e_gnt = '0; e_wd = '0;
            if (g >= 0) begin
                a     = int'(bus.addr[g*AW +: AW]);
                ok    = a < int'(DEPTH);
                wr    = bus.we[g] && !(PRIO && g == 0);
                e_gnt = NREQ'(1) << g;
                e_wd  = bus.wdata[g*DW +: DW];
            end
            check("gnt",       32'(bus.gnt),       32'(e_gnt));
            check("mem_en",    32'(bus.mem_en),    32'(ok));
            check("mem_we",    32'(bus.mem_we),    32'(ok && wr));
            check("mem_addr",  32'(bus.mem_addr),  32'(a));
            check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
            check("rvalid",    32'(bus.rvalid),    32'(m_rv));
            check("rdata",     32'(bus.rdata),     32'(m_rd));
            check("err",       32'(bus.err),       32'(m_err));

            // Advance the model across the coming rising edge.
            nrv = '0; nrd = '0;
            if (g >= 0 && !wr) begin
                nrv = e_gnt;
                nrd = ok ? board[a] : '0;
            end
            if (g >= 0 && wr && ok) board[a] = e_wd;
            nerr0 = (g >= 0) && (!ok || (PRIO && g == 0 && bus.we[0]));
            to = 0;
            if (m_locked) begin
                o   = m_owner;
                rel = (g == o && !bus.lock[o]) || (!bus.req[o] && !bus.lock[o]);
                if (!rel && m_cnt == int'(MAX_LOCK) - 1) to = 1;
                if (rel || to) begin
                    m_locked = 0;
                    if (!(PRIO && o == 0)) m_rr = (o + 1) % NREQ;
                end else m_cnt++;
            end else if (g >= 0) begin
                if (bus.lock[g]) begin
                    m_locked = 1; m_owner = g; m_cnt = 0;
                end
                if (!(PRIO && g == 0)) m_rr = (g + 1) % NREQ;
            end
            m_err   = (m_err & ~{2{bus.err_clr}}) | {to, nerr0};
            m_rv    = nrv;
            m_rd    = nrd;
            m_ready = 1;
        end
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic set_req(input int i, input bit r, input bit w, input int ad,
                           input int d, input bit l);
        bus.req[i]              = r;
        bus.we[i]               = w;
        bus.addr[i*AW +: AW]    = AW'(ad);
        bus.wdata[i*DW +: DW]   = DW'(d);
        bus.lock[i]             = l;
    endtask

    task automatic clear_all();
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.lock = '0;
        bus.err_clr = 1'b0;
    endtask

`ifdef ARB_VGA_PRIORITY_EN
    int t1_gnt [4] = '{1, 1, 1, 1};
    int t1_rd  [4] = '{5, 5, 5, 5};
`else
    int t1_gnt [4] = '{1, 2, 4, 1};
    int t1_rd  [4] = '{5, 6, 7, 5};
`endif

    int  waited, n0, n1;
    bit  got;

    initial begin
        clear_all();
        bus.mem_rdata = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i]   = DW'(i);
            board[i] = DW'(i);
        end
        repeat (3) @(posedge CLOCK);
        #1 RESET_N = 1'b1;
        step();

        // T1: three readers, round-robin order and read return.
        set_req(0, 1, 0, 5, 0, 0); set_req(1, 1, 0, 6, 0, 0); set_req(2, 1, 0, 7, 0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLOCK);
            check("t1_gnt", 32'(bus.gnt), 32'(t1_gnt[c]));
            if (c > 0) begin
                check("t1_rvalid", 32'(bus.rvalid), 32'(t1_gnt[c-1]));
                check("t1_rdata",  32'(bus.rdata),  32'(t1_rd[c-1]));
            end
            step();
        end
        clear_all();
        @(negedge CLOCK);
        check("t1_last_rvalid", 32'(bus.rvalid), 32'(t1_gnt[3]));
        step();

        // T2: locked read-modify-write by requester 1 while requester 2 waits.
        set_req(1, 1, 0, 30, 0, 1); set_req(2, 1, 1, 100, 2, 0);
        @(negedge CLOCK);
        check("t2_lock_gnt", 32'(bus.gnt), 32'h2);
        step();
        set_req(1, 1, 1, 30, 3, 0);
        @(negedge CLOCK);
        check("t2_wr_gnt",    32'(bus.gnt),    32'h2);
        check("t2_rvalid",    32'(bus.rvalid), 32'h2);
        check("t2_rdata",     32'(bus.rdata),  32'h6);
        check("t2_mem_we",    32'(bus.mem_we), 32'h1);
        step();
        set_req(1, 0, 0, 0, 0, 0);
        @(negedge CLOCK);
        check("t2_gnt2_after", 32'(bus.gnt), 32'h4);
        step();
        clear_all();
        step();
        check("t2_ram30",  32'(ram[30]),  32'h3);
        check("t2_ram100", 32'(ram[100]), 32'h2);

        // T3: lock held idle until forced release; requester 2 waits it out.
        set_req(1, 1, 0, 40, 0, 1); set_req(2, 1, 0, 41, 0, 0);
        @(negedge CLOCK);
        check("t3_lock_gnt", 32'(bus.gnt), 32'h2);
        step();
        set_req(1, 0, 0, 40, 0, 1);
        waited = 0; got = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLOCK);
            if (bus.gnt[2]) begin
                got = 1;
                break;
            end
            waited++;
            step();
        end
        check("t3_gnt2_seen",   32'(got),     32'h1);
        check("t3_hold_cycles", 32'(waited),  32'd32);
        check("t3_err_timeout", 32'(bus.err), 32'h2);
        step();
        clear_all();
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        @(negedge CLOCK);
        check("t3_err_cleared", 32'(bus.err), 32'h0);
        step();

        // T4: out-of-range write, read, and clear colliding with a new error.
        set_req(2, 1, 1, 700, 5, 0);
        @(negedge CLOCK);
        check("t4_wr_gnt",    32'(bus.gnt),    32'h4);
        check("t4_wr_mem_en", 32'(bus.mem_en), 32'h0);
        step();
        clear_all();
        @(negedge CLOCK);
        check("t4_err_range", 32'(bus.err), 32'h1);
        step();
        set_req(2, 1, 0, 700, 0, 0);
        @(negedge CLOCK);
        check("t4_rd_gnt", 32'(bus.gnt), 32'h4);
        step();
        clear_all();
        @(negedge CLOCK);
        check("t4_rd_rvalid", 32'(bus.rvalid), 32'h4);
        check("t4_rd_rdata",  32'(bus.rdata),  32'h0);
        step();
        set_req(1, 1, 0, 800, 0, 0);
        bus.err_clr = 1'b1;
        @(negedge CLOCK);
        check("t4_clr_gnt", 32'(bus.gnt), 32'h2);
        step();
        clear_all();
        @(negedge CLOCK);
        check("t4_err_wins", 32'(bus.err), 32'h1);
        step();

        // T5: requesters 0 and 1 competing continuously.
        set_req(0, 1, 0, 11, 0, 0); set_req(1, 1, 0, 12, 0, 0);
        n0 = 0; n1 = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLOCK);
            if (bus.gnt[0]) n0++;
            if (bus.gnt[1]) n1++;
            step();
        end
        clear_all();
`ifdef ARB_VGA_PRIORITY_EN
        check("t5_gnt0_count", 32'(n0), 32'd4);
        check("t5_gnt1_count", 32'(n1), 32'd0);
`else
        check("t5_gnt0_count", 32'(n0), 32'd2);
        check("t5_gnt1_count", 32'(n1), 32'd2);
`endif
        step();

        // T6: reset right after a read grant; arbitration restarts at rr=0.
        set_req(0, 1, 0, 9, 0, 0);
        @(negedge CLOCK);
        check("t6_gnt0", 32'(bus.gnt), 32'h1);
        step();
        RESET_N = 1'b0;
        set_req(0, 1, 0, 9, 0, 0); set_req(1, 1, 0, 10, 0, 0); set_req(2, 1, 0, 11, 0, 0);
        @(negedge CLOCK);
        check("t6_rvalid_dropped", 32'(bus.rvalid), 32'h0);
        check("t6_mem_addr_rst",   32'(bus.mem_addr), 32'h0);
        step();
        RESET_N = 1'b1;
        @(negedge CLOCK);
        check("t6_no_gnt_release", 32'(bus.gnt), 32'h0);
        step();
        @(negedge CLOCK);
        check("t6_gnt_rr0", 32'(bus.gnt), 32'h1);
        step();
        clear_all();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Shares one single-port board RAM (26x26 cells, 3-bit colour, linear address row*26+col, 676 entries) among NREQ requesters.
- Requester 0: VGA scan reader (read-only). Requester 1: game logic (read/modify/write). Requester 2: board generator (write-only).
- Round-robin arbitration, per-requester read-return routing, a lock for atomic read-modify-write sequences, and sticky error reporting.
- Sits between the requesters and the board RAM, all on one clock domain.

Parameters:
- NREQ, 3, number of requesters.
- AW, 10, address width.
- DW, 3, cell colour width.
- DEPTH, 676, number of valid cells; addresses >= DEPTH are out of range.
- MAX_LOCK, 32, maximum cycles a lock may be held before forced release.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester access request.
- we  in  NREQ  per-requester write enable (1 = write).
- addr  in  NREQ*AW  packed addresses; requester i uses [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data.
- lock  in  NREQ  requester holds the RAM after its grant.
- gnt  out  NREQ  one-hot; access accepted this cycle.
- rvalid  out  NREQ  one-hot; read data valid for requester i.
- rdata  out  DW  read data, shared by all requesters; qualified by rvalid.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, 1-cycle latency.
- err  out  2  sticky error flags: [0] address out of range, [1] lock timeout.
- err_clr  in  1  clears err.

Behaviour:
- Reset values: gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, rr pointer=0, state=IDLE, lock counter=0.
- Requester protocol: hold req, we, addr, wdata and lock stable until the cycle gnt[i]=1. Access completes at that rising edge. Requester may deassert req or present a new request the next cycle.
- Grant path is combinational. At most one gnt bit is set per cycle. mem_en=1 only in a grant cycle; mem_we, mem_addr and mem_wdata come from the granted requester.
- Idle cycles: all mem_* outputs = 0.
- Read return: one cycle after a granted read, rvalid[i]=1 and rdata=mem_rdata, both registered. Back-to-back reads give one read per cycle.
- Round-robin: search starts at rr pointer and wraps modulo NREQ. After a grant to i, rr = (i+1) mod NREQ. With no grant, rr is unchanged.
- FSM IDLE -> LOCKED: a grant to i with lock[i]=1 sets owner=i and lock counter=0.
- In LOCKED:
  - Only owner can be granted; other requests wait.
  - The counter increments every cycle.
  - A granted owner access with lock[owner]=0 is performed, then the FSM goes to IDLE.
  - If req[owner]=0 and lock[owner]=0, the FSM goes to IDLE with no grant that cycle.
  - When the counter reaches MAX_LOCK-1 without release, the FSM goes to IDLE and err[1] is set.
  - rr is unchanged during LOCKED and set to owner+1 on exit.
- Out-of-range address (addr >= DEPTH):
  - The request is still granted.
  - mem_en=0, so a write is suppressed.
  - A read still returns rvalid next cycle with rdata=0.
  - err[0] is set.
- err_clr in the same cycle as a new error: the new error wins and its bit stays 1. Other bits clear.
- Asynchronous reset mid-operation: pending rvalid is dropped, LOCKED is abandoned, and no spurious gnt follows reset release.

Optional Feature:
- Macro ARB_VGA_PRIORITY_EN.
- Defined: req[0] always wins, including during LOCKED of another owner. The lock counter still runs. rr is not updated by requester-0 grants.
- A write request from requester 0 is treated as a read and sets err[0].
- Undefined: requester 0 takes part in plain round-robin and locking like the others.

Test Plan:
- Reset, then req=3'b111, all reads, addr0=5, addr1=6, addr2=7: gnt sequence 001, 010, 100, 001. Each rvalid follows its gnt by 1 cycle with the RAM contents.
- Requester 1 locks (read addr 30, lock=1), then writes addr 30 value 3 with lock=0. req2 is held throughout: gnt2 only after the write; RAM[30]=3.
- Requester 1 locks and then idles with req=0, lock=1: forced release after 32 cycles, err=2'b10, pending req2 granted the next cycle.
- Requester 2 writes addr 700 value 5: gnt2=1, mem_en=0, err[0]=1. A read of 700 returns rvalid with rdata=0. err_clr together with a new range error leaves err[0]=1.
- With ARB_VGA_PRIORITY_EN defined, req0 held continuously plus req1: gnt0 every cycle and req1 starves. Without the macro, grants alternate.
- Assert RESET_N low in the cycle after a read grant: rvalid stays 0, all outputs 0; normal arbitration resumes from rr=0.
